// File: rtl/ror_step_sequencer.sv
// Multi-cycle rotate-right sequencer: feeds a 4-bit barrel shifter in steps of
// at most 3 and loops its result back until the full requested amount is applied.
module ror_step_sequencer #(
  parameter int TOTAL_AMT_W = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [3:0]             in_data_i,
  input  logic [TOTAL_AMT_W-1:0] in_amt_i,
  output logic [3:0]             rot_a_o,
  output logic [1:0]             rot_amt_o,
  input  logic [3:0]             rot_y_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [3:0]             out_data_o,
  output logic [TOTAL_AMT_W-1:0] out_steps_o,
  output logic                   busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [3:0]             r_data;
  logic [TOTAL_AMT_W-1:0] r_rem;
  logic [TOTAL_AMT_W-1:0] r_steps;
  logic [3:0]             r_out_data;
  logic [TOTAL_AMT_W-1:0] r_out_steps;

  logic [1:0]             w_step;
  logic [TOTAL_AMT_W-1:0] w_rem_next;
  logic [TOTAL_AMT_W-1:0] w_steps_next;

  // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    w_step       = (r_rem > TOTAL_AMT_W'(3)) ? 2'd3 : r_rem[1:0];
    w_rem_next   = r_rem - TOTAL_AMT_W'(w_step);
    w_steps_next = r_steps + TOTAL_AMT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_rem       <= '0;
      r_steps     <= '0;
      r_out_data  <= '0;
      r_out_steps <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_data  <= in_data_i;
            r_rem   <= in_amt_i;
            r_steps <= '0;
            if (in_amt_i != '0) begin
              r_state <= S_STEP;
            end else begin
              r_state     <= S_DONE;
              r_out_data  <= in_data_i;
              r_out_steps <= '0;
            end
          end
        end
        S_STEP: begin
          r_data  <= rot_y_i;
          r_rem   <= w_rem_next;
          r_steps <= w_steps_next;
          // The result register is loaded on entry to DONE so it survives the return to IDLE.
          if (w_rem_next == '0) begin
            r_state     <= S_DONE;
            r_out_data  <= rot_y_i;
            r_out_steps <= w_steps_next;
          end
        end
        S_DONE: begin
          if (out_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_state == S_IDLE);
  assign busy_o      = (r_state != S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign rot_a_o     = r_data;
  assign rot_amt_o   = (r_state == S_STEP) ? w_step : 2'd0;
  assign out_data_o  = r_out_data;
  assign out_steps_o = r_out_steps;

endmodule

// File: tb/tb_ror_step_sequencer.sv
// Scoreboard bench for ror_step_sequencer: directed cases from the test plan
// followed by randomized requests against a modular-arithmetic reference model.
module tb_ror_step_sequencer;
  localparam int W = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         in_valid_i = 1'b0;
  logic         in_ready_o;
  logic [3:0]   in_data_i = '0;
  logic [W-1:0] in_amt_i = '0;
  logic [3:0]   rot_a_o;
  logic [1:0]   rot_amt_o;
  logic [3:0]   rot_y_i;
  logic         out_valid_o;
  logic         out_ready_i = 1'b0;
  logic [3:0]   out_data_o;
  logic [W-1:0] out_steps_o;
  logic         busy_o;

  ror_step_sequencer #(.TOTAL_AMT_W(W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_amt_i    (in_amt_i),
    .rot_a_o     (rot_a_o),
    .rot_amt_o   (rot_amt_o),
    .rot_y_i     (rot_y_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_steps_o (out_steps_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] data;
    int         steps;
    int         valid_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         step_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         rand_ready = 1'b0;
  bit         forced_ready = 1'b0;
  bit         prev_valid = 1'b0;
  logic [3:0] last_out = '0;
  int         last_steps = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // External barrel shifter: rotate right one bit at a time.
  function automatic logic [3:0] shifter(input logic [3:0] a, input logic [1:0] n);
    logic [3:0] r;
    r = a;
    for (int i = 0; i < int'(n); i++) r = {r[0], r[3:1]};
    return r;
  endfunction

  always_comb rot_y_i = shifter(rot_a_o, rot_amt_o);

  function automatic exp_t model(input logic [3:0] d, input int amt, input int c);
    exp_t       m;
    logic [7:0] dd;
    dd          = {d, d} >> (amt % 4);
    m.data      = dd[3:0];
    m.steps     = (amt + 2) / 3;
    m.valid_cyc = c + 1 + m.steps;
    return m;
  endfunction

  always @(posedge clk_i) cyc++;

  always @(posedge clk_i) begin
    #2;
    out_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  always @(negedge rst_ni) begin
    exp_q.delete();
    step_q.delete();
    last_out   = '0;
    last_steps = 0;
    prev_valid = 1'b0;
  end

  // Monitor: records accepts and checks every observable output once per cycle.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (in_valid_i && in_ready_o) begin
        exp_q.push_back(model(in_data_i, int'(in_amt_i), cyc));
        for (int k = 0; k < int'(in_amt_i) / 3; k++) step_q.push_back(3);
        if (int'(in_amt_i) % 3 != 0) step_q.push_back(int'(in_amt_i) % 3);
      end
      check("busy_vs_ready", busy_o, !in_ready_o);
      if (busy_o && !out_valid_o) begin
        if (step_q.size() == 0) check("unexpected_step", 1, 0);
        else check("rot_amt_step", rot_amt_o, step_q.pop_front());
      end else begin
        check("rot_amt_idle", rot_amt_o, 0);
      end
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          if (!prev_valid) check("latency_cycle", cyc, exp_q[0].valid_cyc);
          check("out_data", out_data_o, exp_q[0].data);
          check("out_steps", out_steps_o, exp_q[0].steps);
          if (out_ready_i) begin
            last_out   = exp_q[0].data;
            last_steps = exp_q[0].steps;
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_ready_o) begin
        check("hold_data_idle", out_data_o, last_out);
        check("hold_steps_idle", out_steps_o, last_steps);
      end
      prev_valid = out_valid_o;
    end
  end

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready_o, 1);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_out_data", out_data_o, 0);
    check("rst_out_steps", out_steps_o, 0);
    check("rst_rot_a", rot_a_o, 0);
    check("rst_rot_amt", rot_amt_o, 0);
    check("rst_busy", busy_o, 0);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] d, input logic [W-1:0] a);
    int n;
    n          = 0;
    in_data_i  = d;
    in_amt_i   = a;
    in_valid_i = 1'b1;
    do begin
      @(negedge clk_i);
      n++;
    end while (!in_ready_o && n < 200);
    if (!in_ready_o) check("accept_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready_o) && n < 2000) begin
      @(posedge clk_i);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 0, 1);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int n;
    #12;
    check_reset_vals();
    @(posedge clk_i);
    #1;
    rst_ni       = 1'b1;
    forced_ready = 1'b1;

    send(4'b1001, W'(5));
    wait_idle();
    send(4'hA, W'(0));
    wait_idle();
    send(4'b0001, W'(15));
    wait_idle();

    // Backpressure with a competing request held on the input.
    forced_ready = 1'b0;
    send(4'h3, W'(7));
    n = 0;
    while (!out_valid_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!out_valid_o) check("valid_timeout", 0, 1);
    @(posedge clk_i);
    #1;
    in_data_i  = 4'h6;
    in_amt_i   = W'(4);
    in_valid_i = 1'b1;
    repeat (4) begin
      @(negedge clk_i);
      check("no_accept_in_done", in_ready_o, 0);
    end
    @(posedge clk_i);
    #1;
    forced_ready = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("accept_after_release", in_ready_o, 1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    wait_idle();

    // Reset during the second STEP cycle of a 9-step-amount request.
    send(4'h5, W'(9));
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    send(4'hC, W'(4));
    wait_idle();

    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk_i);
      #1;
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ror_step_sequencer.md
Name: ror_step_sequencer

Overview:
- Multi-cycle sequencer placed directly upstream of the 4-bit combinational rotate-right barrel shifter. It both feeds the shifter and consumes its output.
- Accepts a 4-bit word plus a total rotate amount wider than 2 bits. Decomposes the amount into shifter-sized steps of at most 3 and loops the shifter output back into its working register until the full rotation is applied.
- Presents the result on a valid/ready output interface.

Parameters:
- TOTAL_AMT_W, 4, width of the requested total rotate amount (legal 2..8).

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_ni  input  1  asynchronous active-low reset
- in_valid_i  input  1  request valid
- in_ready_o  output  1  sequencer can accept a request
- in_data_i  input  4  word to rotate
- in_amt_i  input  TOTAL_AMT_W  total rotate-right amount
- rot_a_o  output  4  operand driven to barrel shifter
- rot_amt_o  output  2  step amount driven to barrel shifter
- rot_y_i  input  4  barrel shifter result (combinational return)
- out_valid_o  output  1  result valid
- out_ready_i  input  1  downstream accepts result
- out_data_o  output  4  rotated word
- out_steps_o  output  TOTAL_AMT_W  number of shifter steps used for this result
- busy_o  output  1  request in progress (STEP or DONE)

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous, active-low (rst_ni).
- Reset (rst_ni low, asynchronous, at any time including mid-operation):
  - state goes to IDLE; working data, remaining count and step count are cleared to 0.
  - in_ready_o=1, out_valid_o=0, out_data_o=0, out_steps_o=0, rot_a_o=0, rot_amt_o=0, busy_o=0.
  - An in-flight request is discarded with no output.
- State machine IDLE / STEP / DONE:
  - in_ready_o=1 only in IDLE; busy_o=1 in STEP and DONE.
  - out_valid_o=1 only in DONE.
- IDLE:
  - On in_valid_i & in_ready_o: data_q<=in_data_i, rem_q<=in_amt_i, steps_q<=0.
  - Next state is STEP if in_amt_i!=0, else DONE.
  - No accept otherwise.
- STEP:
  - step = min(rem_q,3).
  - rot_a_o=data_q; rot_amt_o=step[1:0].
  - Each cycle: data_q<=rot_y_i, rem_q<=rem_q-step, steps_q<=steps_q+1.
  - When rem_q-step==0, next state is DONE.
  - in_valid_i is ignored.
- Outside STEP: rot_a_o=data_q, rot_amt_o=0.
- DONE:
  - out_data_o=data_q, out_steps_o=steps_q.
  - Both are held stable while out_valid_o=1 and out_ready_i=0.
  - On out_ready_i=1: return to IDLE; out_data_o/out_steps_o keep their last value.
- No reduction of the amount modulo 4. Step sequence is 3,3,...,remainder.
  - Steps = ceil(amt/3).
  - Accept-to-out_valid latency = 1 + ceil(amt/3) cycles, i.e. 1 cycle for amt=0.
- Overlap and back-to-back:
  - No overlap between requests; a new request can only be accepted the cycle after the output handshake completes.
  - If in_valid_i is already high at that point, it is accepted on the first IDLE cycle.
- Arithmetic: rem_q and steps_q are TOTAL_AMT_W bits wide. Neither can overflow, because steps ≤ amt.
- rot_y_i is sampled only in STEP; its value in other states is don't-care.

Test Plan:
- Reset then idle: after reset, in_ready_o=1, out_valid_o=0, all data outputs 0.
- Split rotation: accept in_data=4'b1001, in_amt=5.
  - rot_amt_o sequence is 3 then 2.
  - out_valid_o rises 3 cycles after accept with out_data=4'b1100, out_steps=2.
- Zero amount: accept in_data=4'hA, in_amt=0 -> out_valid 1 cycle later, out_data=4'hA, out_steps=0, rot_amt_o stays 0.
- Maximum amount: accept in_data=4'b0001, in_amt=15.
  - rot_amt_o sequence is 3,3,3,3,3.
  - Result: out_data=4'b0010, out_steps=5, latency 6.
- Backpressure and overlap: hold out_ready_i=0 for 4 cycles in DONE while driving in_valid_i=1 with a new request.
  - Result stays stable; in_ready_o=0 and the second request is not accepted.
  - Release out_ready_i: the second request is accepted on the following cycle.
- Reset mid-operation: assert rst_ni low during the second STEP cycle of an in_amt=9 request.
  - All outputs return to reset values immediately; no out_valid follows.
  - A fresh request after release completes correctly.
